reg_bank: RTL and testbench
===========================

Name: reg_bank

Overview:
- Parametrised successor to the single 4-bit accumulator-style register.
- Holds DEPTH general registers of WIDTH bits behind one shared tristate data bus.
- Supports immediate/bus load, increment, decrement, logical shifts with flags, and a multi-cycle register swap sequenced by an internal FSM.
- Sits in the register-file slice, driven by microcode control lines; drives the processor data bus.

Parameters:
- WIDTH, 4, register and bus width in bits (>=2).
- DEPTH, 4, number of registers (power of two, >=2).
- AW, $clog2(DEPTH), address width; derived localparam, not overridable.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- grst  in  1  global reset; synchronous, active-high.
- lrst  in  1  local synchronous clear of register[waddr].
- op  in  3  operation code, see Behaviour.
- waddr  in  AW  target register.
- saddr  in  AW  swap partner register.
- imm  in  WIDTH  immediate value.
- rd_en  in  1  drive register[raddr] onto bus.
- raddr  in  AW  register driven onto bus.
- bus  inout  WIDTH  shared data bus, tristate.
- busy  out  1  swap in progress, new ops ignored.
- zf  out  1  zero flag of last flag-updating op.
- cf  out  1  carry/borrow/shift-out flag.

Behaviour:
- Reset: grst=1 at edge -> all registers 0, zf=0, cf=0, FSM IDLE, busy=0. grst overrides everything, including mid-swap abort.
- op encoding: 0 NOP, 1 LDI (reg<=imm), 2 LDB (reg<=bus), 3 INC, 4 DEC, 5 SHL (zero fill), 6 SHR (zero fill), 7 SWP.
- Op acceptance:
  - An op is accepted only in IDLE; while busy=1, op and lrst are ignored.
  - In IDLE, lrst=1 clears register[waddr] and takes priority over op; flags unchanged.
- Arithmetic: modulo 2^WIDTH.
  - INC of all-ones -> 0, cf=1.
  - DEC of 0 -> all-ones, cf=1 (borrow).
  - SHL: cf=old MSB. SHR: cf=old LSB.
  - LDI/LDB: cf=0.
  - zf=1 iff result==0 for ops 1-6; NOP, SWP and lrst leave flags unchanged.
- Latency: ops 1-6 update register and flags at the accepting edge; the result is visible on bus the next cycle.
- Bus:
  - rd_en=1 -> bus=register[raddr] combinationally; rd_en=0 -> high-Z.
  - LDB with rd_en=1 in the same cycle is a legal register-to-register move; the old value of raddr is captured.
  - LDB with rd_en=0 loads whatever the external driver places on the bus.
- Swap FSM IDLE -> S1 -> S2 -> IDLE:
  - Accept edge: tmp<=register[waddr]; waddr/saddr latched; -> S1, busy=1.
  - S1 edge: register[wa]<=register[sa]; -> S2.
  - S2 edge: register[sa]<=tmp; -> IDLE, busy=0.
  - Total: 3 edges; a new op is accepted on the edge after S2.
  - waddr==saddr: same sequence, contents unchanged.
  - rd_en during the swap drives current stored values (intermediate state visible).

Optional Feature:
- Macro: REG_BANK_BYPASS_EN.
- Defined: if LDI is accepted with rd_en=1 and raddr==waddr, bus drives imm (the new value) in that same cycle.
- Undefined: bus drives the old stored value in that cycle.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package reg_bank_pkg holds:
  - op encodings as a typedef enum (OP_NOP..OP_SWP).
  - FSM state typedef (ST_IDLE, ST_S1, ST_S2).
- Sub-module reg_bank_alu (combinational): value+op -> result, cf, zf. Instantiated once on the write path.

Test Plan:
- grst mid-swap: LDI r0=3, r1=9; SWP 0,1; assert grst in S1 -> all regs 0, busy=0, flags 0 next cycle.
- INC wrap: LDI r2=4'hF, INC r2 -> r2=0, zf=1, cf=1; then DEC r2 -> 4'hF, zf=0, cf=1.
- Move: LDI r1=4'hA; rd_en=1 raddr=1, LDB waddr=3 -> r3=A; rd_en=0 -> bus reads Z.
- Swap: r0=5, r1=C; SWP 0,1 -> busy high 2 cycles; INC issued while busy is ignored; final r0=C, r1=5.
- Shifts: r0=4'b1001; SHL -> 0010, cf=1; SHR -> 0001, cf=0; lrst waddr=0 -> 0, flags unchanged.
- Bypass: LDI r2=7 with rd_en raddr=2 (old 1) -> bus=7 with REG_BANK_BYPASS_EN, bus=1 without.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: op encodings and swap FSM states shared by the
// register bank and its ALU.
package reg_bank_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LDI = 3'd1,
        OP_LDB = 3'd2,
        OP_INC = 3'd3,
        OP_DEC = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_SWP = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2
    } state_t;

endpackage

// File: rtl/reg_bank_alu.sv
// reg_bank_alu: combinational write-path unit computing the new register
// value plus carry/zero flags for load, inc/dec and shift ops.
module reg_bank_alu
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] result,
    output logic             cf,
    output logic             zf
);

    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

    op_t op_e;

    assign op_e = op_t'(op);

    always_comb begin
        result = value;
        cf     = 1'b0;
        case (op_e)
            OP_LDI, OP_LDB: result = ld_val;
            // extra top bit catches carry on wrap and borrow below zero
            OP_INC: {cf, result} = {1'b0, value} + ONE;
            OP_DEC: {cf, result} = {1'b0, value} - ONE;
            OP_SHL: begin
                result = {value[WIDTH-2:0], 1'b0};
                cf     = value[WIDTH-1];
            end
            OP_SHR: begin
                result = {1'b0, value[WIDTH-1:1]};
                cf     = value[0];
            end
            default: ;
        endcase
    end

    assign zf = (result == '0);

endmodule

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH registers on a shared tristate bus with a 3-edge swap FSM.
// Define REG_BANK_BYPASS_EN to forward an LDI immediate onto the bus in its accept cycle.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             grst,
    input  logic             lrst,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    waddr,
    input  logic [AW-1:0]    saddr,
    input  logic [WIDTH-1:0] imm,
    input  logic             rd_en,
    input  logic [AW-1:0]    raddr,
    inout  logic [WIDTH-1:0] bus,
    output logic             busy,
    output logic             zf,
    output logic             cf
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] tmp;
    logic [AW-1:0]    wa;
    logic [AW-1:0]    sa;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cf;
    logic             alu_zf;
    logic             idle;
    logic             wr_en;
    logic             swp_go;
    op_t              op_e;

    assign op_e   = op_t'(op);
    assign idle   = (state == ST_IDLE);
    assign wr_en  = idle && !lrst &&
                    (op_e inside {OP_LDI, OP_LDB, OP_INC,
                                  OP_DEC, OP_SHL, OP_SHR});
    assign swp_go = idle && !lrst && (op_e == OP_SWP);
    assign ld_val = (op_e == OP_LDI) ? imm : bus;

    reg_bank_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .op    (op),
        .value (regs[waddr]),
        .ld_val(ld_val),
        .result(alu_res),
        .cf    (alu_cf),
        .zf    (alu_zf)
    );

    always_ff @(posedge clk) begin
        if (grst) state <= ST_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (swp_go) next_state = ST_S1;
            ST_S1:   next_state = ST_S2;
            ST_S2:   next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (grst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            tmp <= '0;
            wa  <= '0;
            sa  <= '0;
            zf  <= 1'b0;
            cf  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (lrst) begin
                        regs[waddr] <= '0;
                    end else if (wr_en) begin
                        regs[waddr] <= alu_res;
                        zf          <= alu_zf;
                        cf          <= alu_cf;
                    end else if (swp_go) begin
                        tmp <= regs[waddr];
                        wa  <= waddr;
                        sa  <= saddr;
                    end
                end
                ST_S1:   regs[wa] <= regs[sa];
                ST_S2:   regs[sa] <= tmp;
                default: ;
            endcase
        end
    end

`ifdef REG_BANK_BYPASS_EN
    assign rdata = (wr_en && (op_e == OP_LDI) && (raddr == waddr))
                   ? imm : regs[raddr];
`else
    assign rdata = regs[raddr];
`endif

    assign bus = rd_en ? rdata : 'z;

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed vector table for the corner sequences followed by
// randomized traffic checked against an array-based reference model.
module tb_reg_bank;
    import reg_bank_pkg::*;

    localparam int W   = 4;
    localparam int D   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         grst, lrst, rd_en, ext_en;
    logic [2:0]   op;
    logic [1:0]   waddr, saddr, raddr;
    logic [W-1:0] imm, ext_val;
    wire  [W-1:0] bus;
    logic         busy, zf, cf;

    always #5 clk = ~clk;

    assign bus = ext_en ? ext_val : 'z;

    reg_bank #(.WIDTH(W), .DEPTH(D)) dut (
        .clk  (clk),
        .grst (grst),
        .lrst (lrst),
        .op   (op),
        .waddr(waddr),
        .saddr(saddr),
        .imm  (imm),
        .rd_en(rd_en),
        .raddr(raddr),
        .bus  (bus),
        .busy (busy),
        .zf   (zf),
        .cf   (cf)
    );

    typedef struct {
        logic       g, l;
        logic [2:0] op;
        logic [1:0] wa, sa;
        logic [3:0] imm;
        logic       rd;
        logic [1:0] ra;
        logic       xe;
        logic [3:0] xv;
        logic       cb;
        logic [3:0] eb;
        logic       ezf, ecf, ebusy;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_regs [D];
    int m_zf, m_cf;
    int sw_left, sw_a, sw_b;

    function automatic vec_t mk(
        input logic g, input logic l, input logic [2:0] o,
        input int wa, input int sa, input int im,
        input logic rd, input int ra, input logic xe, input int xv,
        input logic cb, input int eb,
        input logic ezf, input logic ecf, input logic ebusy);
        vec_t v;
        v.g = g; v.l = l; v.op = o;
        v.wa = 2'(wa); v.sa = 2'(sa); v.imm = 4'(im);
        v.rd = rd; v.ra = 2'(ra); v.xe = xe; v.xv = 4'(xv);
        v.cb = cb; v.eb = 4'(eb);
        v.ezf = ezf; v.ecf = ecf; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int model_bus();
        if (rd_en) begin
`ifdef REG_BANK_BYPASS_EN
            if (sw_left == 0 && !lrst && op == OP_LDI && raddr == waddr)
                return int'(imm);
`endif
            return m_regs[raddr];
        end
        return int'(ext_val);
    endfunction

    task automatic model_edge();
        int v, r, c, t;
        bit wr;
        v = m_regs[waddr];
        r = 0; c = 0; wr = 1'b1;
        if (grst) begin
            for (int i = 0; i < D; i++) m_regs[i] = 0;
            m_zf = 0; m_cf = 0; sw_left = 0;
        end else if (sw_left > 0) begin
            sw_left--;
            if (sw_left == 0) begin
                t = m_regs[sw_a];
                m_regs[sw_a] = m_regs[sw_b];
                m_regs[sw_b] = t;
            end
        end else if (lrst) begin
            m_regs[waddr] = 0;
        end else begin
            case (op)
                1: r = int'(imm);
                2: r = rd_en ? m_regs[raddr] : int'(ext_val);
                3: begin r = (v + 1) % MOD; c = (v == MOD - 1); end
                4: begin r = (v + MOD - 1) % MOD; c = (v == 0); end
                5: begin r = (v * 2) % MOD; c = (v >= MOD / 2); end
                6: begin r = v / 2; c = v % 2; end
                7: begin
                    wr = 1'b0; sw_left = 2;
                    sw_a = int'(waddr); sw_b = int'(saddr);
                end
                default: wr = 1'b0;
            endcase
            if (wr) begin
                m_regs[waddr] = r;
                m_zf = (r == 0);
                m_cf = c;
            end
        end
    endtask

    task automatic cycle(input vec_t v, input bit tab, input int idx);
        grst = v.g; lrst = v.l; op = v.op;
        waddr = v.wa; saddr = v.sa; imm = v.imm;
        rd_en = v.rd; raddr = v.ra;
        ext_en = v.xe; ext_val = v.xv;
        #1;
        if (tab) begin
            if (v.cb) chk($sformatf("tab%0d_bus", idx), int'(bus), int'(v.eb));
        end else if (sw_left == 0) begin
            chk($sformatf("rnd%0d_bus", idx), int'(bus), model_bus());
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (tab) begin
            chk($sformatf("tab%0d_zf", idx), int'(zf), int'(v.ezf));
            chk($sformatf("tab%0d_cf", idx), int'(cf), int'(v.ecf));
            chk($sformatf("tab%0d_busy", idx), int'(busy), int'(v.ebusy));
        end else begin
            chk($sformatf("rnd%0d_zf", idx), int'(zf), m_zf);
            chk($sformatf("rnd%0d_cf", idx), int'(cf), m_cf);
            chk($sformatf("rnd%0d_busy", idx), int'(busy), int'(sw_left > 0));
        end
    endtask

    vec_t tab_q [$];
    vec_t rv;
    int   byp_exp;

    initial begin
        grst = 1'b0; lrst = 1'b0; op = '0;
        waddr = '0; saddr = '0; imm = '0;
        rd_en = 1'b0; raddr = '0; ext_en = 1'b0; ext_val = '0;
        for (int i = 0; i < D; i++) m_regs[i] = 0;
        m_zf = 0; m_cf = 0; sw_left = 0; sw_a = 0; sw_b = 0;
`ifdef REG_BANK_BYPASS_EN
        byp_exp = 7;
`else
        byp_exp = 1;
`endif
        // g l op wa sa imm rd ra xe xv cb eb zf cf busy
        tab_q.push_back(mk(1,0,OP_NOP,0,0,0,   0,0,0,0, 0,0,   0,0,0));
        tab_q.push_back(mk(0,0,OP_LDI,0,0,3,   0,0,0,0, 0,0,   0,0,0));
        tab_q.push_back(mk(0,0,OP_LDI,1,0,9,   0,0,0,0, 0,0,   0,0,0));
        tab_q.push_back(mk(0,0,OP_SWP,0,1,0,   0,0,0,0, 0,0,   0,0,1));
        tab_q.push_back(mk(1,0,OP_NOP,0,0,0,   1,0,0,0, 1,3,   0,0,0));
        tab_q.push_back(mk(0,0,OP_NOP,0,0,0,   1,1,0,0, 1,0,   0,0,0));
        tab_q.push_back(mk(0,0,OP_LDI,2,0,15,  0,0,0,0, 0,0,   0,0,0));
        tab_q.push_back(mk(0,0,OP_INC,2,0,0,   1,2,0,0, 1,15,  1,1,0));
        tab_q.push_back(mk(0,0,OP_DEC,2,0,0,   1,2,0,0, 1,0,   0,1,0));
        tab_q.push_back(mk(0,0,OP_NOP,0,0,0,   1,2,0,0, 1,15,  0,1,0));
        tab_q.push_back(mk(0,0,OP_LDI,1,0,10,  0,0,0,0, 0,0,   0,0,0));
        tab_q.push_back(mk(0,0,OP_LDB,3,0,0,   1,1,0,0, 1,10,  0,0,0));
        tab_q.push_back(mk(0,0,OP_NOP,0,0,0,   1,3,0,0, 1,10,  0,0,0));
        tab_q.push_back(mk(0,0,OP_NOP,0,0,0,   0,3,1,5, 1,5,   0,0,0));
        tab_q.push_back(mk(0,0,OP_LDB,0,0,0,   0,0,1,6, 1,6,   0,0,0));
        tab_q.push_back(mk(0,0,OP_NOP,0,0,0,   1,0,0,0, 1,6,   0,0,0));
        tab_q.push_back(mk(0,0,OP_LDI,0,0,5,   0,0,0,0, 0,0,   0,0,0));
        tab_q.push_back(mk(0,0,OP_LDI,1,0,12,  0,0,0,0, 0,0,   0,0,0));
        tab_q.push_back(mk(0,0,OP_SWP,0,1,0,   0,0,0,0, 0,0,   0,0,1));
        tab_q.push_back(mk(0,0,OP_INC,0,0,0,   1,0,0,0, 1,5,   0,0,1));
        tab_q.push_back(mk(0,1,OP_INC,1,0,0,   1,0,0,0, 1,12,  0,0,0));
        tab_q.push_back(mk(0,0,OP_NOP,0,0,0,   1,0,0,0, 1,12,  0,0,0));
        tab_q.push_back(mk(0,0,OP_NOP,0,0,0,   1,1,0,0, 1,5,   0,0,0));
        tab_q.push_back(mk(0,0,OP_SWP,1,1,0,   0,0,0,0, 0,0,   0,0,1));
        tab_q.push_back(mk(0,0,OP_NOP,0,0,0,   0,0,0,0, 0,0,   0,0,1));
        tab_q.push_back(mk(0,0,OP_NOP,0,0,0,   1,1,0,0, 1,5,   0,0,0));
        tab_q.push_back(mk(0,0,OP_LDI,0,0,9,   0,0,0,0, 0,0,   0,0,0));
        tab_q.push_back(mk(0,0,OP_SHL,0,0,0,   1,0,0,0, 1,9,   0,1,0));
        tab_q.push_back(mk(0,0,OP_SHR,0,0,0,   1,0,0,0, 1,2,   0,0,0));
        tab_q.push_back(mk(0,0,OP_SHL,3,0,0,   1,3,0,0, 1,10,  0,1,0));
        tab_q.push_back(mk(0,1,OP_LDI,0,0,5,   1,0,0,0, 1,1,   0,1,0));
        tab_q.push_back(mk(0,0,OP_NOP,0,0,0,   1,0,0,0, 1,0,   0,1,0));
        tab_q.push_back(mk(0,0,OP_LDI,2,0,1,   0,0,0,0, 0,0,   0,0,0));
        tab_q.push_back(mk(0,0,OP_LDI,2,0,7,   1,2,0,0, 1,byp_exp, 0,0,0));
        tab_q.push_back(mk(0,0,OP_NOP,0,0,0,   1,2,0,0, 1,7,   0,0,0));

        @(negedge clk);
        for (int i = 0; i < tab_q.size(); i++) cycle(tab_q[i], 1'b1, i);

        for (int i = 0; i < 400; i++) begin
            rv = mk(($urandom % 50) == 0, ($urandom % 10) == 0,
                    3'($urandom % 8), $urandom % D, $urandom % D,
                    $urandom % MOD, $urandom % 2, $urandom % D,
                    1'b0, $urandom % MOD, 1'b0, 0, 1'b0, 1'b0, 1'b0);
            rv.xe = !rv.rd;
            cycle(rv, 1'b0, i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
